// File: rtl/tmds_line_packer.sv
// Packs active-video pixel pairs into 48-bit line-FIFO words and posts one descriptor per fixed-length segment.
// Latency: word 1 cycle after its odd pixel, descriptor 1 cycle after the segment's last word; a full FIFO drops the segment.
module tmds_line_packer #(
  parameter int SEG_PIX = 640,
  parameter int SEG_W   = 2
) (
  input  logic             rx0_pclk,
  input  logic             rstbtn_n,
  input  logic             video_en,
  input  logic [10:0]      video_vcnt,
  input  logic [7:0]       rx0_red,
  input  logic [7:0]       rx0_green,
  input  logic [7:0]       rx0_blue,
  input  logic             fifo_full,
  output logic [47:0]      fifo_din,
  output logic             fifo_wr_en,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [10:0]      hdr_vcnt,
  output logic [SEG_W-1:0] hdr_seg,
  output logic [9:0]       hdr_len,
  output logic             ovf_sticky,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {IDLE, PACK, DROP} state_e;

  typedef struct packed {
    logic [10:0]      vcnt;
    logic [SEG_W-1:0] seg;
    logic [9:0]       len;
  } desc_t;

  localparam logic [9:0] SEG_PIX_C = 10'(SEG_PIX);

  state_e           state_q, state_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [10:0]      vcnt_q, vcnt_d;
  logic [23:0]      even_q, even_d;
  logic             arm_q, arm_d;
  logic             wr_pend_q, wr_pend_d;
  logic             wr_last_q, wr_last_d;
  logic [47:0]      din_q, din_d;
  desc_t            stage_q, stage_d;
  desc_t            hq0_q, hq0_d;
  desc_t            hq1_q, hq1_d;
  logic [1:0]       hcnt_q, hcnt_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drop_q, drop_d;

  logic [23:0] pixel;
  logic [9:0]  cnt_inc;
  logic        wr_fail;
  logic        push;
  logic        pop;

  assign pixel   = {rx0_red, rx0_green, rx0_blue};
  assign cnt_inc = cnt_q + 10'd1;
  assign wr_fail = wr_pend_q & fifo_full;
  // A pending word closes its segment if it was the SEG_PIX-th pixel or video_en just fell.
  assign push    = wr_pend_q & ~fifo_full & (wr_last_q | ~video_en);
  assign pop     = (hcnt_q != 2'd0) & hdr_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seg_d     = seg_q;
    vcnt_d    = vcnt_q;
    even_d    = even_q;
    arm_d     = arm_q | ~video_en;
    wr_pend_d = 1'b0;
    wr_last_d = 1'b0;
    din_d     = din_q;
    stage_d   = stage_q;
    hq0_d     = hq0_q;
    hq1_d     = hq1_q;
    hcnt_d    = hcnt_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;

    case (state_q)
      IDLE: begin
        if (video_en && arm_q) begin
          state_d = PACK;
          seg_d   = '0;
          vcnt_d  = video_vcnt;
          cnt_d   = 10'd1;
          even_d  = pixel;
        end
      end
      default: begin
        if (!video_en) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == PACK && cnt_q[0]) begin
            wr_pend_d = 1'b1;
            wr_last_d = 1'b1;
            din_d     = {even_q, 24'h0};
            stage_d   = {vcnt_q, seg_q, cnt_q};
          end
        end else if (cnt_q == SEG_PIX_C) begin
          state_d = PACK;
          seg_d   = seg_q + SEG_W'(1);
          vcnt_d  = video_vcnt;
          cnt_d   = 10'd1;
          even_d  = pixel;
        end else begin
          cnt_d = cnt_inc;
          if (state_q == PACK) begin
            if (!cnt_q[0]) begin
              even_d = pixel;
            end else begin
              wr_pend_d = 1'b1;
              wr_last_d = (cnt_inc == SEG_PIX_C);
              din_d     = {even_q, pixel};
              stage_d   = {vcnt_q, seg_q, cnt_inc};
            end
          end
          // Lost mid-segment word: swallow the rest of this segment.
          if (wr_fail && !wr_last_q) state_d = DROP;
        end
      end
    endcase

    if (wr_fail) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    case ({push, pop})
      2'b01: begin
        hq0_d  = hq1_q;
        hcnt_d = hcnt_q - 2'd1;
      end
      2'b10: begin
        if (hcnt_q == 2'd0) begin
          hq0_d  = stage_q;
          hcnt_d = 2'd1;
        end else if (hcnt_q == 2'd1) begin
          hq1_d  = stage_q;
          hcnt_d = 2'd2;
        end else begin
          ovf_d = 1'b1;
        end
      end
      2'b11: begin
        if (hcnt_q == 2'd1) begin
          hq0_d = stage_q;
        end else begin
          hq0_d = hq1_q;
          hq1_d = stage_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rx0_pclk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      seg_q     <= '0;
      vcnt_q    <= '0;
      even_q    <= '0;
      arm_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      wr_last_q <= 1'b0;
      din_q     <= '0;
      stage_q   <= '0;
      hq0_q     <= '0;
      hq1_q     <= '0;
      hcnt_q    <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
      vcnt_q    <= vcnt_d;
      even_q    <= even_d;
      arm_q     <= arm_d;
      wr_pend_q <= wr_pend_d;
      wr_last_q <= wr_last_d;
      din_q     <= din_d;
      stage_q   <= stage_d;
      hq0_q     <= hq0_d;
      hq1_q     <= hq1_d;
      hcnt_q    <= hcnt_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign fifo_wr_en = wr_pend_q & ~fifo_full;
  assign fifo_din   = din_q;
  assign hdr_valid  = (hcnt_q != 2'd0);
  assign hdr_vcnt   = hq0_q.vcnt;
  assign hdr_seg    = hq0_q.seg;
  assign hdr_len    = hq0_q.len;
  assign ovf_sticky = ovf_q;
  assign drop_cnt   = drop_q;

endmodule
